// File: rtl/snowv_pkg.sv
// Shared types and constants for the SNOW-V keystream XOR stage.
package snowv_pkg;

   localparam int unsigned BLOCK_BYTES = 16;
   localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;
   localparam int unsigned LEN_W       = 64;

   typedef logic [BLOCK_W-1:0]     block_t;
   typedef logic [BLOCK_BYTES-1:0] keep_t;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_LAST_WAIT = 2'd2
   } state_e;

   // Byte mask with the low n bytes valid; n==16 yields all ones.
   function automatic keep_t keep_mask(input logic [4:0] n);
      return 16'((17'(1) << n) - 17'(1));
   endfunction

endpackage

// File: rtl/snowv_ks_fifo.sv
// Synchronous keystream FIFO; a push at full succeeds only alongside a pop.
module snowv_ks_fifo
   import snowv_pkg::*;
#(
   parameter int unsigned KS_DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   push,
   input  block_t wdata,
   input  logic   pop,
   output block_t rdata,
   output logic   full,
   output logic   empty
);

   localparam int unsigned AW = $clog2(KS_DEPTH);

   block_t          mem [KS_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(KS_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage has no reset; occupancy tracking alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/snowv_xor_stream.sv
// XORs plaintext blocks with buffered SNOW-V keystream words into framed output.
// Optional build macro SNOWV_XOR_ZERO_MASK_EN zeroes output bytes outside dout_keep.
module snowv_xor_stream
   import snowv_pkg::*;
#(
   parameter int unsigned KS_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ks_valid,
   input  logic [BLOCK_W-1:0]     ks_z,
   input  logic                   msg_start,
   input  logic [LEN_W-1:0]       msg_len,
   input  logic                   din_valid,
   output logic                   din_ready,
   input  logic [BLOCK_W-1:0]     din_data,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [BLOCK_W-1:0]     dout_data,
   output logic [BLOCK_BYTES-1:0] dout_keep,
   output logic                   dout_last,
   output logic                   ks_overflow,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE      = 2'(S_IDLE);
   localparam logic [1:0] ST_RUN       = 2'(S_RUN);
   localparam logic [1:0] ST_LAST_WAIT = 2'(S_LAST_WAIT);

   logic [1:0]       state, state_nxt;
   logic [LEN_W-1:0] remaining, remaining_nxt;
   logic             dout_valid_nxt, dout_last_nxt, ks_overflow_nxt, busy_nxt;
   block_t           dout_data_nxt, data_load, fifo_rdata;
   keep_t            dout_keep_nxt, keep_load;
   logic             fifo_full, fifo_empty, fifo_flush;
   logic             accept, out_done, ks_push, is_last;

   assign din_ready  = (state == ST_RUN) & ~fifo_empty & (~dout_valid | dout_ready);
   assign accept     = din_valid & din_ready & ~msg_start;
   assign out_done   = dout_valid & dout_ready;
   assign ks_push    = ks_valid & (state == ST_RUN) & ~msg_start;
   assign fifo_flush = msg_start | ((state == ST_LAST_WAIT) & out_done);
   assign is_last    = (remaining <= LEN_W'(BLOCK_BYTES));

   snowv_ks_fifo #(
      .KS_DEPTH (KS_DEPTH)
   ) u_ks_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (ks_push),
      .wdata (ks_z),
      .pop   (accept),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, counter and output-register logic.
   always_comb begin
      state_nxt       = state;
      remaining_nxt   = remaining;
      dout_valid_nxt  = dout_valid & ~dout_ready;
      dout_data_nxt   = dout_data;
      dout_keep_nxt   = dout_keep;
      dout_last_nxt   = dout_last;
      ks_overflow_nxt = ks_overflow | (ks_push & fifo_full & ~accept);
      data_load       = din_data ^ fifo_rdata;
      keep_load       = is_last ? keep_mask(remaining[4:0]) : '1;
`ifdef SNOWV_XOR_ZERO_MASK_EN
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
         if (!keep_load[i]) data_load[8*i +: 8] = 8'h00;
      end
`endif
      if (msg_start) begin
         state_nxt       = (msg_len != '0) ? ST_RUN : ST_IDLE;
         remaining_nxt   = msg_len;
         dout_valid_nxt  = 1'b0;
         ks_overflow_nxt = 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept) begin
                  dout_valid_nxt = 1'b1;
                  dout_data_nxt  = data_load;
                  dout_keep_nxt  = keep_load;
                  dout_last_nxt  = is_last;
                  if (is_last) state_nxt = ST_LAST_WAIT;
                  else         remaining_nxt = remaining - LEN_W'(BLOCK_BYTES);
               end
            end
            ST_LAST_WAIT: begin
               if (out_done) state_nxt = ST_IDLE;
            end
            default: ;
         endcase
      end
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         remaining   <= '0;
         dout_valid  <= 1'b0;
         dout_data   <= '0;
         dout_keep   <= '0;
         dout_last   <= 1'b0;
         ks_overflow <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         remaining   <= remaining_nxt;
         dout_valid  <= dout_valid_nxt;
         dout_data   <= dout_data_nxt;
         dout_keep   <= dout_keep_nxt;
         dout_last   <= dout_last_nxt;
         ks_overflow <= ks_overflow_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: doc/snowv_xor_stream.md
SNOWV_XOR_STREAM -- requirements
Module: snowv_xor_stream

Interface
REQ-001 Parameter KS_DEPTH, default 4, keystream FIFO depth in 128-bit words; power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ks_valid  in  1  keystream word present this cycle; no backpressure to generator.
REQ-005 ks_z  in  128  keystream word from SNOW-V generator.
REQ-006 msg_start  in  1  single-cycle pulse that begins a new message.
REQ-007 msg_len  in  64  message length in bytes, sampled on msg_start.
REQ-008 din_valid / din_ready  in / out  1 / 1  plaintext block handshake.
REQ-009 din_data  in  128  plaintext block; byte i = bits [8i+7:8i].
REQ-010 dout_valid / dout_ready  out / in  1 / 1  ciphertext block handshake.
REQ-011 dout_data  out  128  din_data XOR keystream word.
REQ-012 dout_keep  out  16  byte-valid mask; bit i qualifies byte i.
REQ-013 dout_last  out  1  final block of message.
REQ-014 ks_overflow  out  1  sticky flag: keystream word dropped.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, RUN, LAST_WAIT; IDLE->RUN on msg_start with msg_len!=0; msg_len==0 keeps IDLE.
REQ-017 msg_start in any state flushes FIFO, drops output register, clears ks_overflow, reloads byte counter; in RUN/LAST_WAIT it aborts the current message.
REQ-018 In IDLE and LAST_WAIT, ks_valid words are discarded and do not set ks_overflow.
REQ-019 In RUN, ks_valid pushes ks_z; push when full and no pop in the same cycle drops the word and sets ks_overflow.
REQ-020 Push and pop in the same cycle at full shall both succeed and leave occupancy unchanged.
REQ-021 din_ready = (state==RUN) & FIFO non-empty & (!dout_valid | dout_ready); combinational, no dependency on din_valid.
REQ-022 On din_valid&din_ready: pop one keystream word and load the output register with din_data^word; latency exactly 1 cycle.
REQ-023 dout_valid, dout_data, dout_keep and dout_last shall hold stable while dout_valid&!dout_ready.
REQ-024 Remaining-byte counter is 64-bit; it decrements by 16 per accepted block. The block accepted with remaining<=16 is last: dout_keep = (1<<remaining)-1 (0xFFFF when 16), dout_last=1, FSM->LAST_WAIT.
REQ-025 For non-last blocks, dout_keep=0xFFFF and dout_last=0.
REQ-026 LAST_WAIT->IDLE on the dout_valid&dout_ready cycle; residual FIFO words are flushed on that transition.
REQ-027 Full throughput: one block per cycle when FIFO non-empty, din_valid and dout_ready are held high.

Reset
REQ-028 On rst: state IDLE, FIFO empty, dout_valid=0, dout_data=0, dout_keep=0, dout_last=0, din_ready=0, ks_overflow=0, busy=0.
REQ-029 rst overrides msg_start and all handshakes in the same cycle.

Configuration
REQ-030 Macro SNOWV_XOR_ZERO_MASK_EN: when defined, dout_data bytes with dout_keep[i]=0 are forced to 0x00. When undefined, those bytes carry the raw XOR result. Ports are identical in both builds.

Structure
REQ-031 Package snowv_pkg holds the 128-bit block typedef, 16-bit keep typedef, FSM state enum and constant BLOCK_BYTES=16.
REQ-032 Sub-module snowv_ks_fifo (synchronous FIFO, parameter KS_DEPTH, flush input, full/empty outputs) is instantiated once.

Verification
REQ-033 msg_len=32, two ks words, two din blocks of 0 with dout_ready=1 -> dout equals ks words; keep 0xFFFF both; last only on second block.
REQ-034 msg_len=20, din=all 0xFF, ks=0 -> block1 keep 0xFFFF; block2 keep 0x000F, last=1. Macro defined: bytes 4..15 = 0x00; macro undefined: bytes 4..15 = 0xFF.
REQ-035 KS_DEPTH=4, six ks_valid cycles with din_valid=0 -> ks_overflow=1 after the 5th; FIFO holds words 1..4.
REQ-036 dout_ready=0 for 5 cycles mid-message -> dout fields stable, din_ready=0, no FIFO pop; then resume without loss.
REQ-037 msg_start during RUN after 1 of 4 blocks -> FIFO empty, dout_valid=0 next cycle, new msg_len counted from zero.
REQ-038 msg_len=0 with msg_start -> busy stays 0, din_ready stays 0, no dout_valid.
